pmem_arbiter: RTL and testbench

Two-port physical-memory arbiter between the pipelined I-cache and the D-cache. Both caches issue whole-cacheline requests (256-bit lines, 32-bit line-aligned addresses) to a single downstream cacheline adaptor. The arbiter grants one requester at a time and forwards its request downstream. It routes the response back only to the granted requester and holds the grant until the downstream transfer completes.

---
 rtl/pmem_arbiter.sv | 107 ++++++++++
 tb/tb_pmem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: grants one of the I-cache or D-cache the single downstream
// cacheline port and holds that grant until the downstream transfer
// completes. Responses go back only to the granted requester.
// Optional feature macro: PMEM_ARB_ROUND_ROBIN_EN. When it is defined, a tie
// alternates between the two caches. When it is undefined, the D-cache
// always wins a tie.
module pmem_arbiter (
  input  logic         clk,
  input  logic         rst,
  // I-cache side
  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  // D-cache side
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  // downstream cacheline adaptor
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {IDLE, I_SERVE, D_SERVE} state_t;

  state_t r_state, w_next;
  logic   w_i_req, w_d_req;
  logic   w_tie_to_i;   // who wins when both caches request in IDLE

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  logic r_last_d;       // 1 = D-cache was served last
  // Remember who completed the most recent transfer; a stray resp in IDLE
  // does not count as a completion.
  always_ff @(posedge clk) begin
    if (rst)
      r_last_d <= 1'b1;
    else if (mem_resp && r_state != IDLE)
      r_last_d <= (r_state == D_SERVE);
  end
  assign w_tie_to_i = r_last_d;
`else
  assign w_tie_to_i = 1'b0;
`endif

  // State register: the grant decision is registered, so requester inputs
  // never reach the downstream port without passing through IDLE first.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: pick a winner in IDLE, hold the grant until mem_resp even if
  // the requester withdraws (the downstream burst has to finish).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) w_next = w_tie_to_i ? I_SERVE : D_SERVE;
        else if (w_i_req)       w_next = I_SERVE;
        else if (w_d_req)       w_next = D_SERVE;
      end
      I_SERVE: if (mem_resp) w_next = IDLE;
      D_SERVE: if (mem_resp) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Downstream request mux and response steering; all of it is zero in IDLE.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    unique case (r_state)
      I_SERVE: begin
        mem_read    = i_pmem_read;
        mem_address = i_pmem_address;
        i_pmem_resp = mem_resp;
      end
      D_SERVE: begin
        // A writeback goes out before the fill, so write suppresses read.
        mem_read    = d_pmem_read & ~d_pmem_write;
        mem_write   = d_pmem_write;
        mem_address = d_pmem_address;
        mem_wdata   = d_pmem_wdata;
        d_pmem_resp = mem_resp;
      end
      default: ;
    endcase
  end

  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter. It runs directed scenarios and then
// random traffic. A reference model tracks which cache currently owns the
// downstream port and predicts every output on every cycle.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read, d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Model: who holds the bus (0 nobody, 1 I-cache, 2 D-cache), and whether
  // the D-cache finished the latest transfer.
  int owner = 0;
  bit d_went_last = 1'b1;

  // Outputs captured in the most recent checked cycle.
  logic obs_req, obs_iresp, obs_dresp, obs_read;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one cycle at the negedge, then advance the model at the posedge.
  task automatic tick();
    logic        e_rd, e_wr, e_ir, e_dr;
    logic [31:0] e_ad;
    logic [255:0] e_wd;
    @(negedge clk); #1;
    e_rd = 0; e_wr = 0; e_ad = '0; e_wd = '0; e_ir = 0; e_dr = 0;
    if (owner == 1) begin
      e_rd = i_pmem_read; e_ad = i_pmem_address; e_ir = mem_resp;
    end else if (owner == 2) begin
      e_wr = d_pmem_write; e_rd = d_pmem_read && !d_pmem_write;
      e_ad = d_pmem_address; e_wd = d_pmem_wdata; e_dr = mem_resp;
    end
    check("mem_read", mem_read, e_rd);
    check("mem_write", mem_write, e_wr);
    check("mem_address", mem_address, e_ad);
    if (owner != 1) check("mem_wdata", mem_wdata, e_wd);
    check("i_resp", i_pmem_resp, e_ir);
    check("d_resp", d_pmem_resp, e_dr);
    check("i_rdata", i_pmem_rdata, mem_rdata);
    check("d_rdata", d_pmem_rdata, mem_rdata);
    obs_req = mem_read | mem_write; obs_read = mem_read;
    obs_iresp = i_pmem_resp; obs_dresp = d_pmem_resp;
    @(posedge clk);
    if (rst) begin
      owner = 0; d_went_last = 1'b1;
    end else if (owner == 0) begin
      if (i_pmem_read && (d_pmem_read || d_pmem_write))
        owner = (RR && d_went_last) ? 1 : 2;
      else if (i_pmem_read) owner = 1;
      else if (d_pmem_read || d_pmem_write) owner = 2;
    end else if (mem_resp) begin
      d_went_last = (owner == 2);
      owner = 0;
    end
    #1;
  endtask

  // Wait (bounded) until a request goes downstream, then complete it.
  task automatic xfer(input int gap, output int who);
    int k;
    mem_resp = 0;
    k = 0;
    do begin tick(); k++; end while (!obs_req && k < 12);
    if (!obs_req) check("xfer_timeout", 1'b0, 1'b1);
    repeat (gap) tick();
    mem_resp = 1; mem_rdata = {8{$urandom}};
    tick();
    who = obs_iresp ? 1 : (obs_dresp ? 2 : 0);
    mem_resp = 0;
  endtask

  initial begin
    int who;
    int exp_who;
    rst = 1; i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    @(posedge clk); #1;
    tick();
    rst = 0;
    tick();
    check("reset_idle_read", obs_req, 1'b0);

    // Lone I read: forwarded from cycle 1, response in the resp cycle.
    i_pmem_read = 1; i_pmem_address = 32'h0000_0040;
    tick();
    check("lone_i_cycle0", obs_req, 1'b0);
    repeat (4) begin
      tick();
      check("lone_i_fwd", obs_read, 1'b1);
    end
    mem_resp = 1; mem_rdata = {8{32'hA5A5_0001}};
    tick();
    check("lone_i_resp", obs_iresp, 1'b1);
    check("lone_i_no_d", obs_dresp, 1'b0);
    mem_resp = 0; i_pmem_read = 0;
    tick();

    // D writeback then fill at the same line.
    d_pmem_write = 1; d_pmem_read = 1; d_pmem_address = 32'h0000_1000;
    d_pmem_wdata = {8{32'hBEEF_0002}};
    xfer(1, who);
    check("wb_resp_d", who, 2);
    d_pmem_write = 0;
    tick();
    check("fill_dead_cycle", obs_req, 1'b0);
    tick();
    check("fill_forward", obs_read, 1'b1);
    mem_resp = 1; tick(); mem_resp = 0;
    d_pmem_read = 0;
    tick();

    // Both held for four transfers.
    i_pmem_read = 1; d_pmem_read = 1;
    for (int n = 0; n < 4; n++) begin
      xfer(0, who);
      exp_who = RR ? ((n % 2 == 0) ? 1 : 2) : 2;
      check("tie_order", who, exp_who);
    end
    d_pmem_read = 0;
    xfer(0, who);
    check("i_after_d_drops", who, 1);
    i_pmem_read = 0;
    tick();

    // Stray resp in IDLE.
    mem_resp = 1;
    tick();
    check("stray_no_i", obs_iresp, 1'b0);
    check("stray_no_d", obs_dresp, 1'b0);
    mem_resp = 0;
    i_pmem_read = 1; i_pmem_address = 32'h0000_2000;
    tick();
    check("stray_still_idle", obs_req, 1'b0);
    tick();
    check("stray_then_grant", obs_read, 1'b1);
    mem_resp = 1; tick(); mem_resp = 0;

    // Reset mid-transfer, then a tie.
    tick();
    tick();
    check("pre_reset_serving", obs_read, 1'b1);
    rst = 1;
    tick();
    rst = 0; d_pmem_read = 1; d_pmem_address = 32'h0000_3000;
    tick();
    check("post_reset_read", obs_read, 1'b0);
    check("post_reset_iresp", obs_iresp, 1'b0);
    mem_resp = 1; mem_rdata = {8{32'h0C0C_0003}};
    tick();
    who = obs_iresp ? 1 : (obs_dresp ? 2 : 0);
    check("post_reset_tie", who, RR ? 1 : 2);
    mem_resp = 0; i_pmem_read = 0; d_pmem_read = 0;
    tick();

    // Withdrawal: I drops mid-transfer while D waits.
    i_pmem_read = 1; i_pmem_address = 32'h0000_4000;
    tick(); tick();
    check("wd_forward", obs_read, 1'b1);
    i_pmem_read = 0; d_pmem_read = 1; d_pmem_address = 32'h0000_5000;
    repeat (3) begin
      tick();
      check("wd_read_low", obs_req, 1'b0);
    end
    mem_resp = 1; tick(); mem_resp = 0;
    tick();
    check("wd_dead_cycle", obs_req, 1'b0);
    tick();
    check("wd_d_granted", obs_read, 1'b1);
    mem_resp = 1; tick(); mem_resp = 0;
    d_pmem_read = 0;
    tick();

    // Random traffic; the model checks every cycle.
    for (int c = 0; c < 400; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      i_pmem_read    = $urandom_range(0, 1);
      i_pmem_address = $urandom & 32'hFFFF_FFE0;
      d_pmem_read    = $urandom_range(0, 1);
      d_pmem_write   = ($urandom_range(0, 3) == 0);
      d_pmem_address = $urandom & 32'hFFFF_FFE0;
      d_pmem_wdata   = {8{$urandom}};
      mem_rdata      = {8{$urandom}};
      mem_resp       = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
